// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result/flags; define ALU_MUL_EN to add the iterative shift-add multiplier
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iValid,
  output logic             oReady,
  input  logic [3:0]       iOP,
  input  logic [WIDTH-1:0] iRegA,
  input  logic [WIDTH-1:0] iRegB,
  output logic             oValid,
  input  logic             iReady,
  output logic [WIDTH-1:0] oRegC,
  output logic             oNEG,
  output logic             oZERO,
  output logic             oCARRY,
  output logic             oOVF
);
  localparam int SW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic accept, is_mul, mul_done, ld, ld_cy, ld_ov, cy, ov;
  logic [SW-1:0] sh;
  logic [WIDTH:0] sum, dif;
  logic [WIDTH-1:0] res, mul_res, ld_val;
`ifdef ALU_MUL_EN
  logic [SW:0] cnt;
  logic [WIDTH-1:0] ma, mb, acc;
  assign is_mul = iOP == 4'd9;
  assign mul_done = cnt == (SW+1)'(WIDTH);
  assign mul_res = acc;
  always_ff @(posedge iClk) begin
    if (iRst) begin
      cnt <= '0;
      acc <= '0;
      ma <= '0;
      mb <= '0;
    end else if (accept && is_mul) begin
      cnt <= '0;
      acc <= '0;
      ma <= iRegA;
      mb <= iRegB;
    end else if (state == BUSY && !mul_done) begin
      if (mb[cnt[SW-1:0]]) acc <= acc + (ma << cnt);
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign is_mul = 1'b0;
  assign mul_done = 1'b0;
  assign mul_res = '0;
`endif
  assign oReady = state == IDLE;
  assign oValid = state == DONE;
  assign accept = iValid && oReady;
  always_comb begin
    sh = iRegB[SW-1:0];
    sum = {1'b0, iRegA} + {1'b0, iRegB};
    dif = {1'b0, iRegA} - {1'b0, iRegB};
    res = '0;
    case (iOP)
      4'd1: res = sum[WIDTH-1:0];
      4'd2: res = dif[WIDTH-1:0];
      4'd3: res = iRegA & iRegB;
      4'd4: res = iRegA | iRegB;
      4'd5: res = iRegA ^ iRegB;
      4'd6: res = iRegA << sh;
      4'd7: res = iRegA >> sh;
      4'd8: res = $signed(iRegA) >>> sh;
      default: res = '0;
    endcase
    cy = iOP == 4'd1 ? sum[WIDTH] : iOP == 4'd2 ? dif[WIDTH] : 1'b0;
    ov = iOP == 4'd1 ? (iRegA[WIDTH-1] ~^ iRegB[WIDTH-1]) & (sum[WIDTH-1] ^ iRegA[WIDTH-1]) :
         iOP == 4'd2 ? (iRegA[WIDTH-1] ^ iRegB[WIDTH-1]) & (dif[WIDTH-1] ^ iRegA[WIDTH-1]) : 1'b0;
  end
  always_comb begin
    state_nx = state == IDLE ? (accept ? (is_mul ? BUSY : DONE) : IDLE) :
               state == BUSY ? (mul_done ? DONE : BUSY) :
               (iReady ? IDLE : DONE);
    ld = (accept && !is_mul) || (state == BUSY && mul_done);
    ld_val = state == BUSY ? mul_res : res;
    ld_cy = state == IDLE && cy;
    ld_ov = state == IDLE && ov;
  end
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state <= IDLE;
      oRegC <= '0;
      oNEG <= 1'b0;
      oZERO <= 1'b1;
      oCARRY <= 1'b0;
      oOVF <= 1'b0;
    end else begin
      state <= state_nx;
      if (ld) begin
        oRegC <= ld_val;
        oNEG <= ld_val[WIDTH-1];
        oZERO <= ld_val == '0;
        oCARRY <= ld_cy;
        oOVF <= ld_ov;
      end
    end
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked ALU for the CPU execute stage. It accepts one operation per transaction on a valid/ready input port, registers the result and four status flags, and holds them on a valid/ready output port until consumed. Single-cycle ops complete in one clock. An optional iterative shift-add multiplier takes WIDTH clocks. The block generalises the combinational add/sub ALU: configurable width, more ops, carry and overflow flags, and back-pressure.

## Interface
- WIDTH, 32: operand and result width in bits; must be ≥ 2 and a power of two.
- iClk  in  1  clock; all state changes on the rising edge.
- iRst  in  1  reset; synchronous, active-high.
- iValid  in  1  request valid.
- oReady  out  1  block can accept a request.
- iOP  in  4  opcode, sampled on accept.
- iRegA, iRegB  in  WIDTH  operands, sampled on accept.
- oValid  out  1  result and flags valid.
- iReady  in  1  consumer accepts the result.
- oRegC  out  WIDTH  result.
- oNEG  out  1  oRegC[WIDTH-1].
- oZERO  out  1  oRegC == 0.
- oCARRY  out  1  carry out (ADD) or borrow (SUB); 0 for all other ops.
- oOVF  out  1  signed overflow (ADD/SUB); 0 for all other ops.

## Operation
- Opcodes:
  - 0 NOP → 0
  - 1 ADD → A+B
  - 2 SUB → A−B
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 SLL → A << B[log2(WIDTH)-1:0]
  - 7 SRL → logical right shift by the same amount
  - 8 SRA → arithmetic right shift by the same amount
  - 9 MUL → low WIDTH bits of A×B (unsigned)
  - 10–15 → 0
- ADD: oCARRY = bit WIDTH of the (WIDTH+1)-bit sum. oOVF = operands have the same sign and the result sign differs.
- SUB: oCARRY = 1 when A < B (unsigned borrow). oOVF = operands have different signs and the result sign differs from A.
- FSM states:
  - IDLE: oReady=1, oValid=0.
  - BUSY: MUL only. Each clock adds A<<i to the accumulator when B[i]=1, then increments the bit counter i. Exit after i = WIDTH−1.
  - DONE: oValid=1, oReady=0.
- Transitions:
  - IDLE → DONE on accept (iValid & oReady) of a non-MUL op.
  - IDLE → BUSY on accept of MUL.
  - BUSY → DONE after WIDTH clocks.
  - DONE → IDLE on iValid-independent iReady=1.
- Outputs: oRegC and all flags are registers. They update only on entry to DONE and are held stable throughout DONE. After DONE → IDLE they keep their last values, but oValid=0.
- Operands are captured on accept. Changes on iRegA, iRegB or iOP after accept have no effect.

## Timing
- Reset values: state=IDLE, oReady=1, oValid=0, oRegC=0, oNEG=0, oZERO=1, oCARRY=0, oOVF=0. The MUL counter and accumulator are cleared.
- Single-cycle op accepted at edge k → oValid=1 from edge k+1.
- MUL accepted at edge k → oValid=1 from edge k+WIDTH+1.
- Result handshake completes at the first edge with oValid & iReady. oReady=1 from the following cycle.
- Maximum throughput is one op per two clocks. A request is never accepted in the same edge as a result handshake.
- iValid while oReady=0 is ignored; the requester must hold it.
- iRst mid-MUL or in DONE: the pending op is discarded without producing oValid, and all outputs return to reset values on that edge.
- Shift amount of 0 returns A unchanged, with oCARRY=0 and oOVF=0.

## Configuration
- ALU_MUL_EN defined: the BUSY state, counter and accumulator are compiled in, and opcode 9 behaves as above.
- ALU_MUL_EN undefined: no multiplier hardware. Opcode 9 behaves like opcodes 10–15 (result 0, oZERO=1) with single-cycle latency, and BUSY is unreachable.

## Test plan
- Reset check, WIDTH=32: assert iRst for 2 clocks → oReady=1, oValid=0, oRegC=0, oZERO=1, other flags 0.
- ADD 0x7FFFFFFF + 1 → oRegC=0x80000000, oNEG=1, oOVF=1, oCARRY=0, oValid one clock after accept.
- ADD 0xFFFFFFFF + 1 → oRegC=0, oZERO=1, oCARRY=1, oOVF=0.
- SUB 3−5 → oRegC=0xFFFFFFFE, oCARRY=1, oNEG=1.
- SRA 0x80000000 by B=0x24 (amount 4) → 0xF8000000.
- Back-pressure: hold iReady=0 for 5 clocks with iValid=1 → oValid and oRegC stay stable and oReady=0; release iReady → one handshake, then accept next.
- MUL with ALU_MUL_EN: 0x10000 × 0x10001 → 0x00010000 after 33 clocks.
- MUL with ALU_MUL_EN: 7×6 → 42; iRst at clock 10 of the MUL → no oValid, reset values.
- MUL without ALU_MUL_EN: 7×6 → 0 after 1 clock.
